menu_ctrl: RTL and testbench
============================

// Module: menu_ctrl
// PURPOSE
//   Menu/page controller that sits between the board push-buttons and the VGA display path.
//   - Debounces up/down/enter/back and turns each into a one-cycle press pulse.
//   - Keeps the 3-item cursor and publishes the arrow position.
//   - Picks the active page/ROM source and enables the buzzer or piano sub-block.
//   - Applies page changes only at a frame boundary, so the display never tears mid-frame.
// PARAMETERS
//   DEB_CNT  1_000_000  consecutive stable cycles needed to accept a level change (10 ms @100 MHz)
//   ARROW_X  600        arrow x coordinate (constant)
//   Y1       150        arrow y for cursor item 0
//   Y2       340        arrow y for cursor item 1
//   Y3       470        arrow y for cursor item 2
// PORTS
//   clk          in   1   system clock (all logic on rising edge)
//   rst          in   1   asynchronous, active-high reset
//   up,down      in   1   raw buttons, asynchronous, active-high
//   enter,back   in   1   raw buttons, asynchronous, active-high
//   frame_start  in   1   one-cycle pulse in clk domain at start of vertical blank
//   arrow_x      out  11  arrow x, always ARROW_X
//   arrow_y      out  10  Y1/Y2/Y3 for cursor 0/1/2
//   arrow_en     out  1   arrow overlay enable for the displayed page
//   page_sel     out  2   displayed page: 0 HOME, 1 BUZZER, 2 PIANO, 3 VIDEO
//   buzzer_en    out  1   buzzer sub-block enable
//   piano_en     out  1   piano sub-block enable
//   song_sel     out  2   buzzer song: 0 none, 1..3 = cursor item + 1
//   busy         out  1   page change pending (waiting for frame_start)
// BEHAVIOUR
//   Reset: page_sel=0, cursor=0, arrow_y=Y1, arrow_en=1, buzzer_en=0, piano_en=0,
//     song_sel=0, busy=0, all debouncers at stable-low, counters cleared. Reset may assert
//     mid-operation: the pending switch is discarded and debouncers restart.
//   Debounce (per button):
//     - 2-FF synchroniser, then a counter that increments while the synced value differs
//       from the stable level and clears when it matches.
//     - On the DEB_CNT-th consecutive differing cycle the stable level flips.
//     - A 0->1 flip of the stable level registers a one-cycle press pulse.
//     - Raw rise to pulse = DEB_CNT+3 cycles. Glitches shorter than DEB_CNT give no pulse.
//       Release gives no pulse.
//   Event priority when pulses coincide: back > enter > up/down.
//     - up and down in the same cycle: both ignored.
//   Cursor (HOME and BUZZER pages only):
//     - up: 0->2, 1->0, 2->1. down: 0->1, 1->2, 2->0.
//     - arrow_y is registered and follows the cursor 1 cycle later.
//   FSM on the displayed page: HOME, BUZZER, PIANO, VIDEO, plus a one-entry pending register.
//     - HOME + enter: request page cursor+1.
//     - BUZZER + enter: song_sel <= cursor+1 next cycle (no page change); buzzer_en stays 1.
//     - PIANO/VIDEO + enter, up or down: ignored.
//     - Any non-HOME page + back: request HOME. HOME + back: no effect.
//     - A request sets busy=1 and latches the target page.
//     - While busy: further enter/up/down are dropped. back overwrites the target with HOME.
//     - On frame_start while busy: page_sel <= target, cursor <= 0, busy <= 0,
//       enables updated in the same edge.
//     - Request and frame_start in the same cycle: the request waits for the next frame_start.
//   Enables, registered and consistent with page_sel:
//     - arrow_en = 1 on HOME/BUZZER, 0 otherwise.
//     - buzzer_en = 1 only on BUZZER. piano_en = 1 only on PIANO.
//     - Entering HOME clears song_sel to 0.
// CONFIGURATION
//   MENU_AUTOREPEAT_EN defined: a held up/down (stable high) re-issues its press pulse
//     every 16*DEB_CNT cycles after the first pulse, until release.
//   MENU_AUTOREPEAT_EN undefined: exactly one pulse per press; no repeat logic synthesised.
// TESTING (DEB_CNT=4 in bench)
//   T1 reset: assert rst mid-frame -> all outputs at reset values, arrow_y=150.
//   T2 debounce: enter high 3 cycles -> no pulse; high 10 cycles -> one pulse at cycle 7 after
//      the rise.
//   T3 cursor wrap: up from reset -> arrow_y=470; down x2 -> 150 then 340.
//   T4 page switch: cursor 1, enter -> busy=1, page_sel=0 until frame_start;
//      same edge page_sel=2, piano_en=1, arrow_en=0, busy=0.
//   T5 buzzer: enter on item 0 then frame_start -> page 1, buzzer_en=1;
//      down, enter -> song_sel=2; back + frame_start -> page 0, song_sel=0.
//   T6 priority: enter+back pulses in one cycle on page 1 -> HOME request only;
//      up+down together -> cursor unchanged.

Source files
------------

// File: rtl/menu_ctrl.sv
// Push-button menu/page controller: debounced presses drive a 3-item cursor and a page FSM whose
// page switches land only on frame_start. Define MENU_AUTOREPEAT_EN for held up/down auto-repeat.

module menu_debounce #(
  parameter int DEB_CNT = 1_000_000,
  parameter bit REP     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEB_CNT + 1);

  logic          s1, s2, stable, stable_d;
  logic [CW-1:0] cnt;
  logic          rep_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      if (s2 != stable) begin
        if (cnt == CW'(DEB_CNT - 1)) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
      press <= (stable & ~stable_d) | rep_hit;
    end
  end

  if (REP) begin : g_rep
    localparam int RW = $clog2(16 * DEB_CNT + 1);
    logic [RW-1:0] rep_cnt;

    // Counts from the first press pulse; each wrap re-issues the pulse while still held.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                              rep_cnt <= '0;
      else if (!(stable && stable_d) || rep_hit) rep_cnt <= '0;
      else                                  rep_cnt <= rep_cnt + RW'(1);
    end

    assign rep_hit = stable && stable_d && (rep_cnt == RW'(16 * DEB_CNT - 1));
  end else begin : g_norep
    assign rep_hit = 1'b0;
  end
endmodule

module menu_ctrl #(
  parameter int DEB_CNT = 1_000_000,
  parameter int ARROW_X = 600,
  parameter int Y1      = 150,
  parameter int Y2      = 340,
  parameter int Y3      = 470
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  input  logic        enter,
  input  logic        back,
  input  logic        frame_start,
  output logic [10:0] arrow_x,
  output logic [9:0]  arrow_y,
  output logic        arrow_en,
  output logic [1:0]  page_sel,
  output logic        buzzer_en,
  output logic        piano_en,
  output logic [1:0]  song_sel,
  output logic        busy
);
  typedef enum logic [1:0] {
    PG_HOME   = 2'd0,
    PG_BUZZER = 2'd1,
    PG_PIANO  = 2'd2,
    PG_VIDEO  = 2'd3
  } page_t;

`ifdef MENU_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic  up_p, down_p, enter_p, back_p;
  logic  ev_back, ev_enter, ev_up, ev_down;
  page_t page_q, target_q;
  logic [1:0] cursor_q;

  menu_debounce #(.DEB_CNT(DEB_CNT), .REP(AUTOREP)) u_deb_up    (.clk(clk), .rst(rst), .raw(up),    .press(up_p));
  menu_debounce #(.DEB_CNT(DEB_CNT), .REP(AUTOREP)) u_deb_down  (.clk(clk), .rst(rst), .raw(down),  .press(down_p));
  menu_debounce #(.DEB_CNT(DEB_CNT), .REP(1'b0))    u_deb_enter (.clk(clk), .rst(rst), .raw(enter), .press(enter_p));
  menu_debounce #(.DEB_CNT(DEB_CNT), .REP(1'b0))    u_deb_back  (.clk(clk), .rst(rst), .raw(back),  .press(back_p));

  // back beats enter beats cursor moves; opposing moves cancel
  assign ev_back  = back_p;
  assign ev_enter = enter_p & ~back_p;
  assign ev_up    = up_p & ~down_p & ~enter_p & ~back_p;
  assign ev_down  = down_p & ~up_p & ~enter_p & ~back_p;

  assign arrow_x  = 11'(ARROW_X);
  assign page_sel = page_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page_q    <= PG_HOME;
      target_q  <= PG_HOME;
      cursor_q  <= 2'd0;
      busy      <= 1'b0;
      arrow_en  <= 1'b1;
      buzzer_en <= 1'b0;
      piano_en  <= 1'b0;
      song_sel  <= 2'd0;
    end else if (busy) begin
      if (frame_start) begin
        page_q    <= target_q;
        cursor_q  <= 2'd0;
        busy      <= 1'b0;
        arrow_en  <= (target_q == PG_HOME) || (target_q == PG_BUZZER);
        buzzer_en <= (target_q == PG_BUZZER);
        piano_en  <= (target_q == PG_PIANO);
        if (target_q == PG_HOME) song_sel <= 2'd0;
      end else if (ev_back) begin
        target_q <= PG_HOME;
      end
    end else begin
      case (page_q)
        PG_HOME: begin
          if (ev_enter) begin
            target_q <= page_t'(cursor_q + 2'd1);
            busy     <= 1'b1;
          end
        end
        PG_BUZZER: begin
          if (ev_back) begin
            target_q <= PG_HOME;
            busy     <= 1'b1;
          end else if (ev_enter) begin
            song_sel <= cursor_q + 2'd1;
          end
        end
        default: begin
          if (ev_back) begin
            target_q <= PG_HOME;
            busy     <= 1'b1;
          end
        end
      endcase
      if (page_q == PG_HOME || page_q == PG_BUZZER) begin
        if (ev_up)   cursor_q <= (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
        if (ev_down) cursor_q <= (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arrow_y <= 10'(Y1);
    end else begin
      case (cursor_q)
        2'd1:    arrow_y <= 10'(Y2);
        2'd2:    arrow_y <= 10'(Y3);
        default: arrow_y <= 10'(Y1);
      endcase
    end
  end
endmodule

// File: tb/tb_menu_ctrl.sv
// Scoreboarded bench: every change of the output bundle must match the next queued expectation.
module tb_menu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        up, down, enter, back, frame_start;
  logic [10:0] arrow_x;
  logic [9:0]  arrow_y;
  logic        arrow_en, buzzer_en, piano_en, busy;
  logic [1:0]  page_sel, song_sel;

  localparam logic [3:0] UP = 4'b1000, DOWN = 4'b0100, ENTER = 4'b0010, BACK = 4'b0001;

  typedef struct {
    logic [28:0] v;
    int          cyc;
    int          id;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_id = 0;

  menu_ctrl #(.DEB_CNT(4)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .enter(enter), .back(back),
    .frame_start(frame_start), .arrow_x(arrow_x), .arrow_y(arrow_y), .arrow_en(arrow_en),
    .page_sel(page_sel), .buzzer_en(buzzer_en), .piano_en(piano_en), .song_sel(song_sel),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [28:0] mk(input int ay, input bit aen, input int pg, input bit bz,
                                     input bit pn, input int sg, input bit bsy);
    logic [9:0] y;
    logic [1:0] p, s;
    y = ay[9:0];
    p = pg[1:0];
    s = sg[1:0];
    return {11'd600, y, aen, p, bz, pn, s, bsy};
  endfunction

  task automatic expect_at(input logic [28:0] v, input int c);
    exp_t e;
    e.v = v;
    e.cyc = c;
    e.id = n_id;
    n_id++;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    {up, down, enter, back} = m;
    tick(hold);
    {up, down, enter, back} = 4'b0000;
    tick(8);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  // Monitor: each observed change of the outputs pops one expectation.
  initial begin
    logic [28:0] prev, cur;
    exp_t e;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {arrow_x, arrow_y, arrow_en, page_sel, buzzer_en, piano_en, song_sel, busy};
      if (cur !== prev) begin
        prev = cur;
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got %h at cycle %0d, required no change", cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.v || (e.cyc >= 0 && cyc != e.cyc)) begin
            n_fail++;
            $display("FAIL check%0d: got %h at cycle %0d, required %h at cycle %0d",
                     e.id, cur, cyc, e.v, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int c;
    rst = 1'b1;
    {up, down, enter, back, frame_start} = 5'b0;
    expect_at(mk(150, 1, 0, 0, 0, 0, 0), -1);
    tick(3);
    rst = 1'b0;
    tick(2);

    // debounce: 3-cycle glitch must be invisible
    press(ENTER, 3);
    // cursor wrap and moves
    expect_at(mk(470, 1, 0, 0, 0, 0, 0), cyc + 9); press(UP, 10);
    expect_at(mk(150, 1, 0, 0, 0, 0, 0), cyc + 9); press(DOWN, 10);
    expect_at(mk(340, 1, 0, 0, 0, 0, 0), cyc + 9); press(DOWN, 10);
    frame_pulse(); tick(2);

    // page switch to PIANO: busy 8 cycles after the raw rise, applied on frame_start
    expect_at(mk(340, 1, 0, 0, 0, 0, 1), cyc + 8); press(ENTER, 10);
    press(DOWN, 10);
    expect_at(mk(340, 0, 2, 0, 1, 0, 0), cyc + 1);
    expect_at(mk(150, 0, 2, 0, 1, 0, 0), cyc + 2);
    frame_pulse(); tick(2);
    press(UP, 10);
    press(ENTER, 10);

    // mid-operation reset
    expect_at(mk(150, 1, 0, 0, 0, 0, 0), -1);
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);

    // BUZZER request coinciding with frame_start waits for the next one
    c = cyc;
    expect_at(mk(150, 1, 0, 0, 0, 0, 1), c + 8);
    enter = 1'b1; tick(7);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    tick(2); enter = 1'b0; tick(8);
    expect_at(mk(150, 1, 1, 1, 0, 0, 0), cyc + 1); frame_pulse(); tick(2);
    expect_at(mk(340, 1, 1, 1, 0, 0, 0), cyc + 9); press(DOWN, 10);
    expect_at(mk(340, 1, 1, 1, 0, 2, 0), cyc + 8); press(ENTER, 10);
    expect_at(mk(150, 1, 1, 1, 0, 2, 0), cyc + 9); press(UP, 10);

    // enter+back together: back wins, song untouched; moves while busy dropped
    expect_at(mk(150, 1, 1, 1, 0, 2, 1), cyc + 8); press(ENTER | BACK, 10);
    press(DOWN, 10);
    expect_at(mk(150, 1, 0, 0, 0, 0, 0), cyc + 1); frame_pulse(); tick(2);

    // up+down together and back on HOME are no-ops
    press(UP | DOWN, 10);
    press(BACK, 10);
    expect_at(mk(470, 1, 0, 0, 0, 0, 0), cyc + 9); press(UP, 10);

    // VIDEO round trip
    expect_at(mk(470, 1, 0, 0, 0, 0, 1), cyc + 8); press(ENTER, 10);
    expect_at(mk(470, 0, 3, 0, 0, 0, 0), cyc + 1);
    expect_at(mk(150, 0, 3, 0, 0, 0, 0), cyc + 2);
    frame_pulse(); tick(2);
    expect_at(mk(150, 0, 3, 0, 0, 0, 1), cyc + 8); press(BACK, 10);
    expect_at(mk(150, 1, 0, 0, 0, 0, 0), cyc + 1); frame_pulse(); tick(4);

    for (int i = 0; i < 300 && q.size() != 0; i++) tick(1);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL check%0d: never observed, required %h at cycle %0d", e.id, e.v, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
